// File: rtl/bbx_drv.sv
// Random bounding-box triangle driver: LFSR-generated screen-space triangles.
// Optional bubble insertion is enabled by defining BBX_DRV_BUBBLE_EN.
module bbx_drv #(
  parameter int          SIGFIG = 24,
  parameter int          RADIX  = 10,
  parameter int          VERTS  = 3,
  parameter int          AXIS   = 3,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              num_tri,
  input  logic                     halt_RnnnnL,
  input  logic signed [SIGFIG-1:0] screen_RnnnnS [1:0],
  output logic signed [SIGFIG-1:0] tri_R10S [VERTS-1:0][AXIS-1:0],
  output logic                     validTri_R10H,
  output logic [15:0]              tri_count,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] MASK   = 32'h8020_0003;
  localparam logic [31:0] SEED_L = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic signed [SIGFIG-1:0] ONE_L =
    {{(SIGFIG-1){1'b0}}, 1'b1};
  localparam logic signed [SIGFIG-1:0] Z_L = ONE_L << RADIX;

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? MASK : 32'd0);
  endfunction

  // One subtraction folds most overshoot; the rest saturates at the edge.
  function automatic logic signed [SIGFIG-1:0] reduce(
    input logic signed [SIGFIG-1:0] r,
    input logic signed [SIGFIG-1:0] s
  );
    logic signed [SIGFIG-1:0] t;
    t = r;
    if (t >= s) t = t - s;
    if (t >= s) t = s - ONE_L;
    return t;
  endfunction

  state_e                   state_q;
  logic [31:0]              lfsr_q;
  logic [15:0]              cnt_q;
  logic [15:0]              num_q;
  logic                     valid_q;
  logic                     done_q;
  logic signed [SIGFIG-1:0] tri_q [VERTS-1:0][AXIS-1:0];

  logic signed [SIGFIG-1:0] tri_d [VERTS-1:0][AXIS-1:0];
  logic [31:0]              lfsr_v;
  logic [31:0]              lfsr6_d;
  logic [31:0]              lfsr1_d;
  logic signed [SIGFIG-1:0] raw;
  logic                     bubble;

  always_comb begin
    lfsr_v = lfsr_q;
    raw    = '0;
    for (int v = 0; v < VERTS; v++) begin
      for (int a = 0; a < AXIS; a++) begin
        tri_d[v][a] = (a == 2) ? Z_L : '0;
      end
    end
    for (int k = 0; k < 2*VERTS; k++) begin
      lfsr_v = step(lfsr_v);
      raw    = {1'b0, lfsr_v[SIGFIG-2:0]};
      tri_d[k/2][k%2] = reduce(raw, screen_RnnnnS[k%2]);
    end
    lfsr6_d = lfsr_v;
    lfsr1_d = step(lfsr_q);
  end

`ifdef BBX_DRV_BUBBLE_EN
  assign bubble = lfsr_q[31];
`else
  assign bubble = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_L;
      cnt_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int v = 0; v < VERTS; v++) begin
        for (int a = 0; a < AXIS; a++) begin
          tri_q[v][a] <= '0;
        end
      end
    end else begin
      done_q <= 1'b0;
      if (halt_RnnnnL) begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              cnt_q   <= '0;
              num_q   <= num_tri;
              state_q <= (num_tri == 16'd0) ? DONE : RUN;
            end
          end
          RUN: begin
            if (bubble) begin
              valid_q <= 1'b0;
              lfsr_q  <= lfsr1_d;
            end else begin
              tri_q   <= tri_d;
              valid_q <= 1'b1;
              cnt_q   <= cnt_q + 16'd1;
              lfsr_q  <= lfsr6_d;
              if (cnt_q + 16'd1 == num_q) state_q <= DONE;
            end
          end
          DONE: begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tri_R10S      = tri_q;
  assign validTri_R10H = valid_q;
  assign tri_count     = cnt_q;
  assign done          = done_q;

endmodule

// File: tb/tb_bbx_drv.sv
// Directed self-checking bench for bbx_drv (default build).
// Expected coordinates are hand-derived from the seed-1 Galois sequence.
module tb_bbx_drv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b1;
  logic [15:0] num = '0;
  logic signed [23:0] scr [1:0];
  logic signed [23:0] tri_o [2:0][2:0];
  logic valid, done;
  logic [15:0] cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bbx_drv dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_tri(num),
    .halt_RnnnnL(halt),
    .screen_RnnnnS(scr),
    .tri_R10S(tri_o),
    .validTri_R10H(valid),
    .tri_count(cnt),
    .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] n);
    start = 1'b1;
    num = n;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    halt = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    bad = 0;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        if (tri_o[v][a] !== 24'sd0) bad++;
    checks++;
    if (bad != 0 || valid !== 1'b0 || done !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset: valid=%b done=%b cnt=%0d nonzero=%0d, want 0",
               valid, done, cnt, bad);
    end
    rst = 1'b0;
    halt = 1'b1;
  endtask

  task automatic test_values;
    int e [9];
    do_reset();
    scr[0] = 24'sd2000000;
    scr[1] = 24'sd4000000;
    e = '{97155, 3145730, 1024, 1572865, 2883587, 1024,
          1538946, 1769473, 1024};
    go(1);
    tick();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (tri_o[i/3][i%3] !== 24'(e[i])) begin
        failures++;
        $display("FAIL values[%0d]: got %0d want %0d",
                 i, tri_o[i/3][i%3], e[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL values_done: done=%b valid=%b want 1/0", done, valid);
    end
    tick();
  endtask

  task automatic test_clamp;
    int e [9];
    do_reset();
    scr[0] = 24'sd1048576;
    scr[1] = 24'sd786432;
    e = '{1048575, 786431, 1024, 524289, 786431, 1024,
          1048575, 786431, 1024};
    go(1);
    tick();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (tri_o[i/3][i%3] !== 24'(e[i])) begin
        failures++;
        $display("FAIL clamp[%0d]: got %0d want %0d",
                 i, tri_o[i/3][i%3], e[i]);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_zero;
    int vseen;
    int dcyc;
    vseen = 0;
    dcyc = 0;
    go(0);
    if (valid) vseen++;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_early: done=%b want 0", done);
    end
    tick();
    if (valid) vseen++;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_pulse: done=%b want 1", done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid) vseen++;
      if (done) dcyc++;
    end
    checks++;
    if (vseen != 0 || dcyc != 0) begin
      failures++;
      $display("FAIL zero_after: valid_cycles=%0d extra_done=%0d want 0/0",
               vseen, dcyc);
    end
  endtask

  task automatic test_three;
    go(3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || cnt !== 16'(i) || done !== 1'b0) begin
        failures++;
        $display("FAIL three_%0d: valid=%b cnt=%0d done=%b want 1/%0d/0",
                 i, valid, cnt, done, i);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL three_done: valid=%b done=%b want 0/1", valid, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL three_clear: done=%b want 0", done);
    end
  endtask

  task automatic test_stall;
    logic signed [23:0] snap [9];
    int bad;
    int incs;
    logic [15:0] prev;
    logic seen;
    go(5);
    tick();
    tick();
    for (int i = 0; i < 9; i++) snap[i] = tri_o[i/3][i%3];
    halt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      bad = 0;
      for (int i = 0; i < 9; i++)
        if (tri_o[i/3][i%3] !== snap[i]) bad++;
      checks++;
      if (bad != 0 || valid !== 1'b1 || cnt !== 16'd2 || done !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: moved=%0d valid=%b cnt=%0d want 0/1/2",
                 c, bad, valid, cnt);
      end
    end
    halt = 1'b1;
    incs = 0;
    prev = cnt;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (cnt != prev) incs++;
      prev = cnt;
      seen = done;
    end
    checks++;
    if (!seen || incs != 3 || cnt !== 16'd5) begin
      failures++;
      $display("FAIL stall_total: done=%b incs=%0d cnt=%0d want 1/3/5",
               seen, incs, cnt);
    end
    tick();
  endtask

  task automatic test_range;
    int bad;
    logic seen;
    scr[0] = 24'sd1048576;
    scr[1] = 24'sd786432;
    go(1000);
    seen = 1'b0;
    for (int c = 0; c < 1100 && !seen; c++) begin
      tick();
      seen = done;
      if (valid) begin
        bad = 0;
        for (int v = 0; v < 3; v++) begin
          if (tri_o[v][0] < 0 || tri_o[v][0] >= 24'sd1048576) bad++;
          if (tri_o[v][1] < 0 || tri_o[v][1] >= 24'sd786432) bad++;
          if (tri_o[v][2] !== 24'sd1024) bad++;
        end
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL range cnt=%0d: out_of_range=%0d want 0", cnt, bad);
        end
      end
    end
    checks++;
    if (!seen || cnt !== 16'd1000) begin
      failures++;
      $display("FAIL range_total: done=%b cnt=%0d want 1/1000", seen, cnt);
    end
    tick();
  endtask

  task automatic test_abort;
    int e1 [6];
    int e2 [4];
    do_reset();
    scr[0] = 24'sd4000000;
    scr[1] = 24'sd4000000;
    e1 = '{2097155, 3145730, 1572865, 2883587, 3538946, 1769473};
    e2 = '{2981891, 3588098, 1794049, 3188483};
    go(10);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (cnt !== 16'd4) begin
      failures++;
      $display("FAIL abort_mid: cnt=%0d want 4", cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL abort_reset: valid=%b done=%b cnt=%0d want 0/0/0",
               valid, done, cnt);
    end
    go(2);
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tri_o[i/2][i%2] !== 24'(e1[i])) begin
        failures++;
        $display("FAIL abort_t1[%0d]: got %0d want %0d",
                 i, tri_o[i/2][i%2], e1[i]);
      end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tri_o[i/2][i%2] !== 24'(e2[i])) begin
        failures++;
        $display("FAIL abort_t2[%0d]: got %0d want %0d",
                 i, tri_o[i/2][i%2], e2[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || cnt !== 16'd2) begin
      failures++;
      $display("FAIL abort_done: done=%b cnt=%0d want 1/2", done, cnt);
    end
    tick();
  endtask

  task automatic test_valid_count;
    int vc;
    logic seen;
    go(10);
    vc = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (valid) vc++;
      seen = done;
    end
    checks++;
    if (!seen || vc != 10 || cnt !== 16'd10) begin
      failures++;
      $display("FAIL valid_count: done=%b valid_cycles=%0d cnt=%0d want 1/10/10",
               seen, vc, cnt);
    end
    tick();
  endtask

  initial begin
    scr[0] = 24'sd1048576;
    scr[1] = 24'sd786432;
    test_reset();
    test_values();
    test_clamp();
    test_zero();
    test_three();
    test_stall();
    test_range();
    test_abort();
    test_valid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bbx_drv.md
BBX_DRV -- requirements
Module: bbx_drv

Interface
REQ-001 SHALL have parameter SIGFIG, default 24: bits per coordinate.
REQ-002 SHALL have parameter RADIX, default 10: fraction bits per coordinate.
REQ-003 SHALL have parameter VERTS, default 3: vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3: axes per vertex (x,y,z).
REQ-005 SHALL have parameter SEED, default 32'h0000_0001: LFSR reset value; a SEED of 0 SHALL load as 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE.
REQ-009 SHALL have port num_tri, input, 16 bits: triangles per run; sampled on accepted start.
REQ-010 SHALL have port halt_RnnnnL, input, 1 bit: active-low halt; 1 = advance, 0 = stall.
REQ-011 SHALL have port screen_RnnnnS[1:0], input, signed SIGFIG bits each: screen width and height.
REQ-012 SHALL have port tri_R10S[VERTS-1:0][AXIS-1:0], output, signed SIGFIG bits each: triangle vertices.
REQ-013 SHALL have port validTri_R10H, output, 1 bit: tri_R10S holds a valid triangle.
REQ-014 SHALL have port tri_count, output, 16 bits: triangles issued in the current run.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at end of run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE SHALL go to RUN on start=1 when num_tri>0, and directly to DONE when num_tri=0; tri_count SHALL clear on the accepted start.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 In RUN, each edge with halt_RnnnnL=1 SHALL load a new triangle into tri_R10S, set validTri_R10H=1, increment tri_count and advance the LFSR.
REQ-020 Any edge with halt_RnnnnL=0 SHALL hold tri_R10S, validTri_R10H, tri_count, the LFSR and the FSM state unchanged.
REQ-021 RUN SHALL go to DONE on the enabled edge that brings tri_count to num_tri.
REQ-022 In DONE, the next enabled edge SHALL clear validTri_R10H, set done=1 and go to IDLE.
REQ-023 done SHALL clear on the following edge regardless of halt_RnnnnL.
REQ-024 LFSR SHALL be 32-bit Galois, mask 32'h8020_0003, and SHALL be stepped 6 times per triangle, unrolled in one cycle.
REQ-025 The coordinate for step k SHALL be r = {0, lfsr_k[SIGFIG-2:0]}, in order v0.x, v0.y, v1.x, v1.y, v2.x, v2.y.
REQ-026 Coordinate reduction: if r >= screen, r SHALL be reduced by one subtraction of screen; if still >= screen, it SHALL be clamped to screen-1. x uses screen_RnnnnS[0] and y uses screen_RnnnnS[1]. Every x and y SHALL lie in [0, screen).
REQ-027 Every z coordinate SHALL be (1 << RADIX).
REQ-028 Arithmetic SHALL be signed SIGFIG bits; screen values SHALL be positive (0 < screen < 2^(SIGFIG-1)).

Reset
REQ-029 While rst=1 at an edge, SHALL set: state=IDLE, tri_R10S=0, validTri_R10H=0, tri_count=0, done=0, LFSR=SEED (or 1 if SEED=0); rst SHALL override halt_RnnnnL.
REQ-030 rst asserted mid-run SHALL abort the run with no done pulse; the next start SHALL reproduce the sequence from SEED.

Configuration
REQ-031 Macro BBX_DRV_BUBBLE_EN, when defined: on an enabled RUN edge where current LFSR bit 31 = 1, SHALL issue a bubble (validTri_R10H=0, LFSR stepped once, tri_count unchanged, tri_R10S held). The triangle total per run SHALL still equal num_tri.
REQ-032 Macro BBX_DRV_BUBBLE_EN, when undefined: SHALL issue no bubbles; triangles SHALL be back-to-back while halt_RnnnnL=1.

Verification
REQ-033 Reset: rst=1 for 2 cycles -> all outputs 0, state IDLE.
REQ-034 num_tri=0, start pulse -> done=1 exactly one cycle, two edges after start; validTri_R10H never 1.
REQ-035 num_tri=3, halt_RnnnnL=1, no bubble macro -> validTri_R10H high 3 consecutive cycles, tri_count 1,2,3, done pulse on the next cycle.
REQ-036 num_tri=5, halt_RnnnnL=0 for 4 cycles after the 2nd triangle -> tri_R10S, validTri_R10H and tri_count=2 stable during the stall; exactly 5 triangles total.
REQ-037 screen=(1024<<10, 768<<10), num_tri=1000 -> every x < 1048576, every y < 786432, every x and y >= 0, every z = 1024.
REQ-038 rst asserted at tri_count=4 of 10, then start with num_tri=2 -> the first 2 triangles match the first 2 triangles of a fresh run; with BBX_DRV_BUBBLE_EN defined, a 10-triangle run yields exactly 10 valid cycles.
